// File: rtl/fetch_pkg.sv
// Shared fetch-path constants: buffer geometry and half-load enable encodings.
package fetch_pkg;

  localparam int unsigned FB_HALF_BYTES = 16;
  localparam int unsigned FB_BYTES      = 32;
  localparam int unsigned FB_PTR_W      = 5;
  localparam int unsigned FB_HALF_W     = FB_HALF_BYTES * 8;
  localparam int unsigned FB_BUF_W      = FB_BYTES * 8;

  localparam logic [1:0] FB_LD_LO = 2'b01;
  localparam logic [1:0] FB_LD_HI = 2'b10;

endpackage

// File: rtl/fetch_rot32.sv
// Combinational rotator: selects 16 consecutive bytes of a 32-byte ring starting at ptr.
module fetch_rot32
  import fetch_pkg::*;
(
  input  logic [FB_BUF_W-1:0]  data,
  input  logic [FB_PTR_W-1:0]  ptr,
  output logic [FB_HALF_W-1:0] win
);

  logic [FB_PTR_W-1:0] idx;

  always_comb begin
    win = '0;
    idx = '0;
    for (int i = 0; i < int'(FB_HALF_BYTES); i++) begin
      idx = FB_PTR_W'(ptr + FB_PTR_W'(i));
      win[i*8 +: 8] = data[{idx, 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/fetch_buf.sv
// Two-half 32-byte instruction fetch buffer with a wrap-around 16-byte decode window.
// Optional stall counter enabled by defining FETCH_BUF_STAT_EN.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           f_ld_buf,
  input  logic [FB_HALF_W-1:0] ic_data,
  input  logic                 ld_eip,
  input  logic [FB_PTR_W-1:0]  eip_lo,
  input  logic                 de_adv,
  input  logic [3:0]           instr_len,
  output logic [FB_HALF_W-1:0] de_bytes,
  output logic                 de_p,
  output logic                 r_V_de,
  output logic [1:0]           buf_v
`ifdef FETCH_BUF_STAT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  logic [FB_BUF_W-1:0] buf_q;
  logic [FB_PTR_W-1:0] ptr_q, ptr_d, ptr_sum;
  logic [1:0]          v_q, v_d;
  logic                adv;

  // A window that starts mid-half spills into the other half and needs it valid too.
  assign r_V_de = v_q[ptr_q[FB_PTR_W-1]] &&
                  ((ptr_q[FB_PTR_W-2:0] == '0) || v_q[~ptr_q[FB_PTR_W-1]]);
  assign de_p   = ptr_q[FB_PTR_W-1];
  assign buf_v  = v_q;

  assign adv     = de_adv && r_V_de && (instr_len != 4'd0);
  assign ptr_sum = FB_PTR_W'(ptr_q + FB_PTR_W'(instr_len));

  // Per-half priority: load sets valid over redirect/advance clear over hold.
  always_comb begin
    ptr_d = ptr_q;
    v_d   = v_q;
    if (ld_eip) begin
      ptr_d = eip_lo;
      v_d   = 2'b00;
    end else if (adv) begin
      ptr_d = ptr_sum;
      if (ptr_sum[FB_PTR_W-1] != ptr_q[FB_PTR_W-1]) begin
        v_d[ptr_q[FB_PTR_W-1]] = 1'b0;
      end
    end
    v_d = v_d | f_ld_buf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      ptr_q <= '0;
      v_q   <= 2'b00;
    end else begin
      ptr_q <= ptr_d;
      v_q   <= v_d;
      if ((f_ld_buf & FB_LD_LO) != 2'b00) buf_q[FB_HALF_W-1:0]        <= ic_data;
      if ((f_ld_buf & FB_LD_HI) != 2'b00) buf_q[FB_BUF_W-1:FB_HALF_W] <= ic_data;
    end
  end

  fetch_rot32 u_rot (
    .data (buf_q),
    .ptr  (ptr_q),
    .win  (de_bytes)
  );

`ifdef FETCH_BUF_STAT_EN
  // Saturating count of cycles decode starves outside a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (!r_V_de && !ld_eip && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_buf.sv
// Self-checking bench for fetch_buf: byte-array reference model plus directed literal checks.
module tb_fetch_buf;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   f_ld_buf = 2'b00;
  logic [127:0] ic_data = '0;
  logic         ld_eip = 1'b0;
  logic [4:0]   eip_lo = 5'd0;
  logic         de_adv = 1'b0;
  logic [3:0]   instr_len = 4'd0;
  logic [127:0] de_bytes;
  logic         de_p;
  logic         r_V_de;
  logic [1:0]   buf_v;
`ifdef FETCH_BUF_STAT_EN
  logic [15:0]  stall_cnt;
`endif

  always #5 clk = ~clk;

  fetch_buf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_ld_buf  (f_ld_buf),
    .ic_data   (ic_data),
    .ld_eip    (ld_eip),
    .eip_lo    (eip_lo),
    .de_adv    (de_adv),
    .instr_len (instr_len),
    .de_bytes  (de_bytes),
    .de_p      (de_p),
    .r_V_de    (r_V_de),
    .buf_v     (buf_v)
`ifdef FETCH_BUF_STAT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain byte array, integer pointer, valid bits.
  logic [7:0] mb [32];
  int         mptr;
  logic [1:0] mv;
  int         mcnt;

  function automatic logic m_rv();
    int h;
    h = mptr / 16;
    return mv[h] && ((mptr % 16) == 0 || mv[1 - h]);
  endfunction

  function automatic logic [127:0] m_win();
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[i*8 +: 8] = mb[(mptr + i) % 32];
    return w;
  endfunction

  function automatic logic [127:0] line(int base);
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[i*8 +: 8] = 8'(base + i);
    return l;
  endfunction

  function automatic logic [7:0] db(int i);
    return de_bytes[i*8 +: 8];
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    logic rv;
    int   oh;
    int   np;
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) mb[k] = 8'h00;
      mptr = 0;
      mv   = 2'b00;
      mcnt = 0;
    end else begin
      rv = m_rv();
      oh = mptr / 16;
      if (!rv && !ld_eip && mcnt < 65535) mcnt++;
      if (ld_eip) begin
        mptr = int'(eip_lo);
        mv   = 2'b00;
      end else if (de_adv && rv && instr_len != 4'd0) begin
        np = (mptr + int'(instr_len)) % 32;
        if (np / 16 != oh) mv[oh] = 1'b0;
        mptr = np;
      end
      for (int h = 0; h < 2; h++) begin
        if (f_ld_buf[h]) begin
          for (int k = 0; k < 16; k++) mb[h*16 + k] = ic_data[k*8 +: 8];
          mv[h] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    chk("m_de_bytes", de_bytes, m_win());
    chk("m_de_p", 128'(de_p), 128'(mptr / 16));
    chk("m_r_V_de", 128'(r_V_de), 128'(m_rv()));
    chk("m_buf_v", 128'(buf_v), 128'(mv));
`ifdef FETCH_BUF_STAT_EN
    chk("m_stall_cnt", 128'(stall_cnt), 128'(mcnt));
`endif
  end

  task automatic cyc(logic [1:0] fld, logic [127:0] d, logic ld, logic [4:0] eip,
                     logic adv, logic [3:0] len);
    f_ld_buf  = fld;
    ic_data   = d;
    ld_eip    = ld;
    eip_lo    = eip;
    de_adv    = adv;
    instr_len = len;
    @(negedge clk);
    #1;
    f_ld_buf = 2'b00;
    ld_eip   = 1'b0;
    de_adv   = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    #1;
    chk("rst_de_bytes", de_bytes, 128'd0);
    chk("rst_buf_v", 128'(buf_v), 128'd0);
    chk("rst_r_V_de", 128'(r_V_de), 128'd0);
    chk("rst_de_p", 128'(de_p), 128'd0);
    rst_n = 1'b1;

    // Stalled advances are ignored and counted
    for (int i = 0; i < 5; i++) cyc(2'b00, '0, 1'b0, 5'd0, 1'b1, 4'd4);
    chk("ign_adv_buf_v", 128'(buf_v), 128'd0);
`ifdef FETCH_BUF_STAT_EN
    chk("stall5", 128'(stall_cnt), 128'd5);
`endif

    // 1: fill lower half
    cyc(2'b01, line(8'h00), 1'b0, 5'd0, 1'b0, 4'd0);
    chk("t1_buf_v", 128'(buf_v), 128'd1);
    chk("t1_r_V_de", 128'(r_V_de), 128'd1);
    chk("t1_b0", 128'(db(0)), 128'h00);
    chk("t1_b15", 128'(db(15)), 128'h0F);
    chk("t1_de_p", 128'(de_p), 128'd0);

    // 2: spill window
    cyc(2'b00, '0, 1'b0, 5'd0, 1'b1, 4'd6);
    chk("t2_b0", 128'(db(0)), 128'h06);
    chk("t2_r_V_de0", 128'(r_V_de), 128'd0);
    cyc(2'b10, line(8'h10), 1'b0, 5'd0, 1'b0, 4'd0);
    chk("t2_r_V_de1", 128'(r_V_de), 128'd1);
    chk("t2_b15", 128'(db(15)), 128'h15);
    cyc(2'b00, '0, 1'b0, 5'd0, 1'b1, 4'd0);
    chk("t2_len0_b0", 128'(db(0)), 128'h06);

    // 3: half crossing, plain then with same-cycle reload of the vacated half
    cyc(2'b00, '0, 1'b0, 5'd0, 1'b1, 4'd6);
    chk("t3_b0_12", 128'(db(0)), 128'h0C);
    chk("t3_buf_v11", 128'(buf_v), 128'd3);
    cyc(2'b00, '0, 1'b0, 5'd0, 1'b1, 4'd5);
    chk("t3_b0_17", 128'(db(0)), 128'h11);
    chk("t3_de_p", 128'(de_p), 128'd1);
    chk("t3_buf_v10", 128'(buf_v), 128'd2);
    cyc(2'b01, line(8'h00), 1'b1, 5'd12, 1'b0, 4'd0);
    cyc(2'b10, line(8'h10), 1'b0, 5'd0, 1'b0, 4'd0);
    chk("t3_rel_b0", 128'(db(0)), 128'h0C);
    cyc(2'b01, line(8'h40), 1'b0, 5'd0, 1'b1, 4'd5);
    chk("t3_ld_buf_v", 128'(buf_v), 128'd3);
    chk("t3_ld_b15", 128'(db(15)), 128'h40);

    // 4: wrap past byte 31
    cyc(2'b00, '0, 1'b0, 5'd0, 1'b1, 4'd11);
    chk("t4_b0_28", 128'(db(0)), 128'h1C);
    cyc(2'b00, '0, 1'b0, 5'd0, 1'b1, 4'd7);
    chk("t4_b0_3", 128'(db(0)), 128'h43);
    chk("t4_de_p", 128'(de_p), 128'd0);
    chk("t4_buf_v", 128'(buf_v), 128'd1);

    // 5: redirect beats advance, same-cycle load survives
    cyc(2'b10, line(8'h50), 1'b1, 5'h1A, 1'b1, 4'd3);
    chk("t5_b0", 128'(db(0)), 128'h5A);
    chk("t5_buf_v", 128'(buf_v), 128'd2);
    chk("t5_r_V_de", 128'(r_V_de), 128'd0);
    chk("t5_de_p", 128'(de_p), 128'd1);

    // 6: ignored advance while not ready, then async reset mid-cycle
    for (int i = 0; i < 3; i++) cyc(2'b00, '0, 1'b0, 5'd0, 1'b1, 4'd4);
    chk("t6_b0", 128'(db(0)), 128'h5A);
    cyc(2'b01, line(8'h60), 1'b0, 5'd0, 1'b0, 4'd0);
    chk("t6_r_V_de", 128'(r_V_de), 128'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_buf_v", 128'(buf_v), 128'd0);
    chk("t6_rst_bytes", de_bytes, 128'd0);
    chk("t6_rst_r_V_de", 128'(r_V_de), 128'd0);
`ifdef FETCH_BUF_STAT_EN
    chk("t6_rst_stall", 128'(stall_cnt), 128'd0);
`endif
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc(2'b00, '0, 1'b0, 5'd0, 1'b0, 4'd0);
    cyc(2'b00, '0, 1'b0, 5'd0, 1'b0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
